// File: rtl/divresult_to_double_if.sv
// Bundle between the divider result, the double converter and the downstream consumer.
// dout is a valid/ready channel: a word transfers on a rising clock edge where dout_valid and dout_ready are both high; dout_valid and dout stay stable until that edge.
interface divresult_to_double_if;
  logic [63:0] result;
  logic        signresult;
  logic [6:0]  dotplaceresult;
  logic        calcover;
  logic [63:0] dout;
  logic        dout_valid;
  logic        dout_ready;

  modport slave (
    input  result, signresult, dotplaceresult, calcover, dout_ready,
    output dout, dout_valid
  );

  modport master (
    output result, signresult, dotplaceresult, calcover, dout_ready,
    input  dout, dout_valid
  );
endinterface

// File: rtl/divresult_to_double.sv
// Converts the divider's sign/magnitude/dot-place result into a packed IEEE-754 double:
// left-normalise one bit per cycle, round to nearest even, then hold the word until it is accepted.
module divresult_to_double #(
  parameter int RES_W    = 64,
  parameter int DOT_W    = 7,
  parameter int EXP_BIAS = 1023
) (
  input  logic                 systclk,
  input  logic                 init,
  divresult_to_double_if.slave bus,
  output logic                 busy,
  output logic                 ovr_err,
  output logic [1:0]           state_dbg
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    NORM = 2'd1,
    RND  = 2'd2,
    HOLD = 2'd3
  } state_t;

  // Exponent of a magnitude whose MSB is already at bit RES_W-1 with no fractional bits.
  localparam logic [11:0] EXP_TOP = 12'(EXP_BIAS + RES_W - 1);

  state_t             state, state_nx;
  logic [RES_W-1:0]   mag, mag_nx;
  logic [5:0]         shift, shift_nx;
  logic               sgn, sgn_nx;
  logic [DOT_W-1:0]   dot, dot_nx;
  logic               calcover_d;
  logic [63:0]        dout_q, dout_nx;
  logic               valid_q, valid_nx;
  logic               ovr_nx;

  logic               start, accept, capture;
  logic               guard, sticky, inc;
  logic [52:0]        man_sum;
  logic [11:0]        exp_base, exp_rnd;

  assign start   = bus.calcover & ~calcover_d;
  assign accept  = (state == HOLD) & bus.dout_ready;
  // A start coinciding with the accepting handshake is taken immediately, not flagged.
  assign capture = start & ((state == IDLE) | accept);

  assign guard    = mag[10];
  assign sticky   = |mag[9:0];
  assign inc      = guard & (sticky | mag[11]);
  assign man_sum  = {1'b0, mag[62:11]} + 53'(inc);
  assign exp_base = EXP_TOP - {6'b0, shift} - {{(12-DOT_W){1'b0}}, dot};
  // A mantissa carry out leaves man_sum[51:0] at zero and bumps the exponent.
  assign exp_rnd  = exp_base + 12'(man_sum[52]);

  always_comb begin
    state_nx = state;
    mag_nx   = mag;
    shift_nx = shift;
    sgn_nx   = sgn;
    dot_nx   = dot;
    dout_nx  = dout_q;
    valid_nx = valid_q;
    ovr_nx   = ovr_err | (start & ~capture);

    case (state)
      IDLE: ;
      NORM: begin
        if (mag[RES_W-1]) begin
          state_nx = RND;
        end else begin
          mag_nx   = mag << 1;
          shift_nx = shift + 6'd1;
        end
      end
      RND: begin
        state_nx = HOLD;
        valid_nx = 1'b1;
        if (mag == '0) dout_nx = {sgn, 63'b0};
        else           dout_nx = {sgn, exp_rnd[10:0], man_sum[51:0]};
      end
      HOLD: begin
        if (bus.dout_ready) begin
          valid_nx = 1'b0;
          state_nx = IDLE;
        end
      end
      default: state_nx = IDLE;
    endcase

    if (capture) begin
      mag_nx   = bus.result;
      sgn_nx   = bus.signresult;
      dot_nx   = bus.dotplaceresult;
      shift_nx = '0;
      state_nx = (bus.result == '0) ? RND : NORM;
    end
  end

  always_ff @(posedge systclk or negedge init) begin
    if (!init) begin
      state      <= IDLE;
      mag        <= '0;
      shift      <= '0;
      sgn        <= 1'b0;
      dot        <= '0;
      calcover_d <= 1'b1;
      dout_q     <= '0;
      valid_q    <= 1'b0;
      ovr_err    <= 1'b0;
    end else begin
      state      <= state_nx;
      mag        <= mag_nx;
      shift      <= shift_nx;
      sgn        <= sgn_nx;
      dot        <= dot_nx;
      calcover_d <= bus.calcover;
      dout_q     <= dout_nx;
      valid_q    <= valid_nx;
      ovr_err    <= ovr_nx;
    end
  end

  assign bus.dout       = dout_q;
  assign bus.dout_valid = valid_q;
  assign busy           = (state != IDLE);
  assign state_dbg      = state;

endmodule

// File: tb/tb_divresult_to_double.sv
// Bench for divresult_to_double: directed cases plus random magnitudes against an arithmetic
// model of the double conversion (MSB search, round-half-even on the dropped bits).
module tb_divresult_to_double;
  logic        systclk = 1'b0;
  logic        init;
  logic        busy, ovr_err;
  logic [1:0]  state_dbg;

  divresult_to_double_if bus();

  divresult_to_double dut (
    .systclk   (systclk),
    .init      (init),
    .bus       (bus),
    .busy      (busy),
    .ovr_err   (ovr_err),
    .state_dbg (state_dbg)
  );

  int          checks = 0;
  int          errors = 0;
  logic        exp_ovr = 1'b0;
  logic [63:0] exp_q[$];
  logic [63:0] held;

  // clock
  always #5 systclk = ~systclk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic int msb_pos(input logic [63:0] r);
    int p;
    p = 63;
    while (p > 0 && r[p] == 1'b0) p--;
    return p;
  endfunction

  function automatic logic [63:0] ref_double(input logic [63:0] r, input logic s, input int d);
    int p, sh, e;
    logic [63:0] q, rem, half;
    if (r == 64'd0) return {s, 63'b0};
    p = msb_pos(r);
    if (p <= 52) begin
      q = r << (52 - p);
    end else begin
      sh   = p - 52;
      q    = r >> sh;
      rem  = r & ((64'd1 << sh) - 64'd1);
      half = 64'd1 << (sh - 1);
      if (rem > half || (rem == half && q[0])) q = q + 64'd1;
      if (q[53]) begin
        q = q >> 1;
        p = p + 1;
      end
    end
    e = p - d + 1023;
    return {s, e[10:0], q[51:0]};
  endfunction

  function automatic int ref_latency(input logic [63:0] r);
    if (r == 64'd0) return 1;
    return (63 - msb_pos(r)) + 2;
  endfunction

  // driver: present a result and raise calcover for one capture edge
  task automatic start_conv(input logic [63:0] r, input logic s, input logic [6:0] d,
                            input logic with_ready);
    @(negedge systclk);
    bus.result         = r;
    bus.signresult     = s;
    bus.dotplaceresult = d;
    bus.calcover       = 1'b1;
    bus.dout_ready     = with_ready;
    exp_q.push_back(ref_double(r, s, int'(d)));
    @(posedge systclk);
    #1;
    check("busy_after_capture", 64'(busy), 64'd1);
    check("valid_after_capture", 64'(bus.dout_valid), 64'd0);
    @(negedge systclk);
    bus.calcover   = 1'b0;
    bus.dout_ready = 1'b0;
  endtask

  task automatic wait_result(input logic [63:0] r, input logic poke);
    int cyc;
    logic got;
    cyc = 0;
    got = 1'b0;
    while (cyc < 100 && !got) begin
      @(posedge systclk);
      #1;
      cyc++;
      if (poke && cyc == 3) begin
        bus.calcover = 1'b1;
        exp_ovr      = 1'b1;
      end
      if (poke && cyc == 4) bus.calcover = 1'b0;
      got = bus.dout_valid;
    end
    check("valid_seen", 64'(got), 64'd1);
    check("latency", 64'(cyc), 64'(ref_latency(r)));
    held = (exp_q.size() > 0) ? exp_q.pop_front() : 64'hDEAD_BEEF_DEAD_BEEF;
    check("dout", bus.dout, held);
    check("busy_hold", 64'(busy), 64'd1);
    check("ovr_err", 64'(ovr_err), 64'(exp_ovr));
  endtask

  task automatic hold_accept(input int n);
    repeat (n) begin
      @(posedge systclk);
      #1;
      check("hold_valid", 64'(bus.dout_valid), 64'd1);
      check("hold_dout", bus.dout, held);
    end
    @(negedge systclk);
    bus.dout_ready = 1'b1;
    @(posedge systclk);
    #1;
    check("accept_valid", 64'(bus.dout_valid), 64'd0);
    check("accept_dout", bus.dout, held);
    check("accept_busy", 64'(busy), 64'd0);
    @(negedge systclk);
    bus.dout_ready = 1'b0;
  endtask

  initial begin
    logic [63:0] r;
    int p;

    init               = 1'b1;
    bus.result         = '0;
    bus.signresult     = 1'b0;
    bus.dotplaceresult = '0;
    bus.calcover       = 1'b0;
    bus.dout_ready     = 1'b0;
    #1 init = 1'b0;
    repeat (3) @(posedge systclk);
    #1;
    check("rst_dout", bus.dout, 64'd0);
    check("rst_valid", 64'(bus.dout_valid), 64'd0);
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_ovr", 64'(ovr_err), 64'd0);
    check("rst_state", 64'(state_dbg), 64'd0);
    @(negedge systclk);
    init = 1'b1;

    // unity with 5 cycles of backpressure
    start_conv(64'h0020_0000_0000_0000, 1'b0, 7'd53, 1'b0);
    wait_result(64'h0020_0000_0000_0000, 1'b0);
    check("unity_const", bus.dout, 64'h3FF0_0000_0000_0000);
    hold_accept(5);

    // max shift, with a lost calcover edge during normalisation
    start_conv(64'd1, 1'b1, 7'd0, 1'b0);
    wait_result(64'd1, 1'b1);
    check("maxshift_const", bus.dout, 64'hBFF0_0000_0000_0000);

    // back-to-back: accept and start on the same edge, negative zero follows
    start_conv(64'd0, 1'b1, 7'd9, 1'b1);
    wait_result(64'd0, 1'b0);
    check("zero_const", bus.dout, 64'h8000_0000_0000_0000);
    hold_accept(2);

    start_conv(64'hFFFF_FFFF_FFFF_FC00, 1'b0, 7'd0, 1'b0);
    wait_result(64'hFFFF_FFFF_FFFF_FC00, 1'b0);
    check("carry_const", bus.dout, 64'h43F0_0000_0000_0000);
    hold_accept(0);

    start_conv(64'h8000_0000_0000_0400, 1'b0, 7'd0, 1'b0);
    wait_result(64'h8000_0000_0000_0400, 1'b0);
    check("tie_const", bus.dout, 64'h43E0_0000_0000_0000);
    hold_accept(1);

    // dout_ready in IDLE does nothing
    @(negedge systclk);
    bus.dout_ready = 1'b1;
    repeat (3) @(posedge systclk);
    #1;
    check("idle_ready_valid", 64'(bus.dout_valid), 64'd0);
    check("idle_ready_busy", 64'(busy), 64'd0);
    check("idle_ready_dout", bus.dout, 64'h43E0_0000_0000_0000);
    @(negedge systclk);
    bus.dout_ready = 1'b0;

    for (int i = 0; i < 24; i++) begin
      p = $urandom_range(0, 63);
      r = {$urandom, $urandom};
      if (p < 63) r = r & ((64'd1 << (p + 1)) - 64'd1);
      r[p] = 1'b1;
      case ($urandom_range(0, 4))
        0:       r = 64'd0;
        1:       if (p >= 11) r[10:0] = 11'h400;
        default: ;
      endcase
      start_conv(r, 1'($urandom_range(0, 1)), 7'($urandom_range(0, 127)), 1'b0);
      wait_result(r, 1'b0);
      hold_accept($urandom_range(0, 3));
    end

    // reset during normalisation with calcover held high
    @(negedge systclk);
    bus.result         = 64'd1;
    bus.signresult     = 1'b0;
    bus.dotplaceresult = 7'd0;
    bus.calcover       = 1'b1;
    repeat (6) @(posedge systclk);
    #1;
    check("pre_reset_busy", 64'(busy), 64'd1);
    @(negedge systclk);
    init = 1'b0;
    exp_ovr = 1'b0;
    #1;
    check("mid_rst_dout", bus.dout, 64'd0);
    check("mid_rst_valid", 64'(bus.dout_valid), 64'd0);
    check("mid_rst_busy", 64'(busy), 64'd0);
    check("mid_rst_ovr", 64'(ovr_err), 64'd0);
    check("mid_rst_state", 64'(state_dbg), 64'd0);
    @(negedge systclk);
    init = 1'b1;
    repeat (10) @(posedge systclk);
    #1;
    check("post_rst_busy", 64'(busy), 64'd0);
    check("post_rst_valid", 64'(bus.dout_valid), 64'd0);
    check("post_rst_state", 64'(state_dbg), 64'd0);
    @(negedge systclk);
    bus.calcover = 1'b0;

    start_conv(64'h0000_0000_0000_0C00, 1'b1, 7'd10, 1'b0);
    wait_result(64'h0000_0000_0000_0C00, 1'b0);
    check("post_rst_const", bus.dout, 64'hC008_0000_0000_0000);
    hold_accept(1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
